// File: rtl/risc16b_mem_pkg.sv
// Shared types and constants for the risc16b memory responder.
package risc16b_mem_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } run_state_t;

  localparam logic [15:0] HALT_ADDR_DEFAULT = 16'hFFFE;

endpackage

// File: rtl/risc16b_dmem_array.sv
// Word-organised 16-bit RAM: two combinational read ports, one registered
// read port and one write port with big-endian byte-lane enables.
module risc16b_dmem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [15:0]       ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [15:0]       rb_data,
  input  logic              rq_en,
  input  logic [ADDR_W-1:0] rq_addr,
  output logic [15:0]       rq_data,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_data
);

  logic [15:0] mem [2**ADDR_W];

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  // Lane 0 is the even (high) byte, lane 1 the odd (low) byte.
  always_ff @(posedge clk) begin
    if (we[0]) mem[w_addr][15:8] <= w_data[15:8];
    if (we[1]) mem[w_addr][7:0]  <= w_data[7:0];
    if (rq_en) rq_data <= mem[rq_addr];
  end

endmodule

// File: rtl/risc16b_mem_responder.sv
// Memory responder for the risc16b core: shared RAM, host load/dump port and
// the run-control FSM that drives the core's reset.
module risc16b_mem_responder
  import risc16b_mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  output logic        cpu_rst,
  input  logic        start,
  output logic        done,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic [31:0] run_cycles,
  output logic [1:0]  state_dbg
);

  run_state_t        state;
  logic              core_wr;
  logic              host_xfer;
  logic              halt_store;
  logic              rdata_loaded;
  logic [1:0]        w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_data;
  logic [15:0]       i_word;
  logic [15:0]       d_word;
  logic [15:0]       q_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[15:ADDR_W+1], i_addr[0],
                              host_addr[15:ADDR_W+1], host_addr[0]};
  assign state_dbg = state;

  // Host handshake: a transfer happens on any edge where host_valid and
  // host_ready are both high; host_ready depends only on the state register,
  // and a read answers with host_rvalid/host_rdata on the following cycle.
  assign host_xfer  = host_valid && host_ready;
  assign core_wr    = (state == RUN) && !rst;
  assign halt_store = (d_we == 2'b11) && (d_addr == HALT_ADDR);

  always_comb begin
    w_en   = 2'b00;
    w_addr = d_addr[ADDR_W:1];
    w_data = d_dout;
    if (core_wr) begin
      w_en = d_we;
    end else if (host_xfer && host_we) begin
      w_en   = 2'b11;
      w_addr = host_addr[ADDR_W:1];
      w_data = host_wdata;
    end
  end

  risc16b_dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .ra_addr (i_addr[ADDR_W:1]),
    .ra_data (i_word),
    .rb_addr (d_addr[ADDR_W:1]),
    .rb_data (d_word),
    .rq_en   (host_xfer && !host_we),
    .rq_addr (host_addr[ADDR_W:1]),
    .rq_data (q_word),
    .we      (w_en),
    .w_addr  (w_addr),
    .w_data  (w_data)
  );

  assign i_din = i_oe ? i_word : 16'h0000;
  assign d_din = d_oe ? d_word : 16'h0000;
  // The array has no reset, so read data is masked until the first host read.
  assign host_rdata = rdata_loaded ? q_word : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      host_ready   <= 1'b1;
      host_rvalid  <= 1'b0;
      rdata_loaded <= 1'b0;
      run_cycles   <= 32'd0;
    end else begin
      host_rvalid <= host_xfer && !host_we;
      if (host_xfer && !host_we) rdata_loaded <= 1'b1;
      case (state)
        HOLD, HALTED: begin
          if (start) begin
            state      <= RUN;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            host_ready <= 1'b0;
            run_cycles <= 32'd0;
          end
        end
        RUN: begin
          if (run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
          if (halt_store) begin
            state      <= HALTED;
            cpu_rst    <= 1'b1;
            done       <= 1'b1;
            host_ready <= 1'b1;
          end
        end
        default: begin
          state      <= HOLD;
          cpu_rst    <= 1'b1;
          done       <= 1'b0;
          host_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc16b_mem_responder.sv
// Directed self-checking bench for risc16b_mem_responder.
module tb_risc16b_mem_responder;
  import risc16b_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_oe;
  logic [15:0] i_din;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [15:0] d_din;
  logic [15:0] d_dout;
  logic [1:0]  d_we;
  logic        cpu_rst;
  logic        start;
  logic        done;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [31:0] run_cycles;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_errors;
  int tick_count;
  int t0;
  int exp_run;
  logic [15:0] exp_q[$];

  risc16b_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_oe        (i_oe),
    .i_din       (i_din),
    .d_addr      (d_addr),
    .d_oe        (d_oe),
    .d_din       (d_din),
    .d_dout      (d_dout),
    .d_we        (d_we),
    .cpu_rst     (cpu_rst),
    .start       (start),
    .done        (done),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .run_cycles  (run_cycles),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    tick_count++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic host_write(input logic [15:0] addr, input logic [15:0] data);
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_valid = 1'b0;
    host_we    = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = addr;
    exp_q.push_back(exp);
    tick();
    host_valid = 1'b0;
    check({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    check(tag, {16'd0, host_rdata}, {16'd0, exp_q.pop_front()});
  endtask

  task automatic core_store(input logic [15:0] addr, input logic [1:0] we, input logic [15:0] data);
    d_addr = addr;
    d_we   = we;
    d_dout = data;
    tick();
    d_we   = 2'b00;
  endtask

  task automatic core_load(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    d_addr = addr;
    d_oe   = 1'b1;
    #1;
    check(tag, {16'd0, d_din}, {16'd0, exp});
    d_oe   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = tick_count;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; tick_count = 0; t0 = 0;
    rst = 1'b1; start = 1'b0;
    i_addr = 16'h0; i_oe = 1'b0; d_addr = 16'h0; d_oe = 1'b0;
    d_dout = 16'h0; d_we = 2'b00;
    host_valid = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 16'h0;
    tick(); tick();
    rst = 1'b0;

    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd1);
    check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_rdata", {16'd0, host_rdata}, 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, HOLD});

    host_write(16'h0010, 16'h1234);
    host_write(16'h0002, 16'h5A5A);
    host_write(16'h0000, 16'h1111);
    host_read("hread_0010", 16'h0010, 16'h1234);
    tick();
    check("rvalid_pulse", {31'd0, host_rvalid}, 32'd0);

    i_addr = 16'h2002; i_oe = 1'b1; #1;
    check("ifetch_wrap", {16'd0, i_din}, 32'h5A5A);
    i_oe = 1'b0; #1;
    check("ifetch_oe0", {16'd0, i_din}, 32'h0);

    core_store(16'h0010, 2'b11, 16'hDEAD);
    core_load("hold_store_dropped", 16'h0010, 16'h1234);

    pulse_start();
    check("start_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("start_state", {30'd0, state_dbg}, {30'd0, RUN});
    check("start_host_ready", {31'd0, host_ready}, 32'd0);
    i_oe = 1'b1; i_addr = 16'h0000;
    tick();
    i_oe = 1'b0;

    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0000; host_wdata = 16'hFFFF;
    check("run_host_ready", {31'd0, host_ready}, 32'd0);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
    core_load("run_host_ignored", 16'h0000, 16'h1111);

    core_store(16'h0011, 2'b01, 16'hAB00);
    core_load("lane_hi", 16'h0010, 16'hAB34);
    core_store(16'h0011, 2'b10, 16'h00CD);
    core_load("lane_lo", 16'h0010, 16'hABCD);

    start = 1'b1;
    tick();
    start = 1'b0;

    d_addr = 16'h0010; d_we = 2'b11; d_dout = 16'h7777; d_oe = 1'b1; #1;
    check("rw_same_old", {16'd0, d_din}, 32'hABCD);
    tick();
    d_we = 2'b00; #1;
    check("rw_same_new", {16'd0, d_din}, 32'h7777);
    d_oe = 1'b0;

    core_store(16'hFFFE, 2'b11, 16'hBEEF);
    exp_run = tick_count - t0;
    check("halt_done", {31'd0, done}, 32'd1);
    check("halt_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("halt_state", {30'd0, state_dbg}, {30'd0, HALTED});
    check("halt_run_cycles", run_cycles, exp_run);
    tick(); tick();
    check("halted_hold_count", run_cycles, exp_run);
    host_read("halt_word", 16'hFFFE, 16'hBEEF);
    host_read("word0_kept", 16'h0000, 16'h1111);

    core_store(16'h0002, 2'b11, 16'h9999);
    core_load("halted_store_dropped", 16'h0002, 16'h5A5A);

    pulse_start();
    check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_count", run_cycles, 32'd0);
    tick(); tick(); tick();
    check("restart_count3", run_cycles, 32'd3);

    rst = 1'b1; d_addr = 16'h0002; d_we = 2'b11; d_dout = 16'h4444;
    tick();
    rst = 1'b0; d_we = 2'b00;
    check("midrst_state", {30'd0, state_dbg}, {30'd0, HOLD});
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_count", run_cycles, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    host_read("midrst_store_dropped", 16'h0002, 16'h5A5A);
    host_read("midrst_ram_kept", 16'h0010, 16'h7777);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
